// File: rtl/vector_lane_fu_sequencer.sv
// -----------------------------------------------------------------------------
// vector_lane_fu_sequencer
//
// Purpose
//   Per-lane issue sequencer for the vector lane functional units (arithmetic,
//   multiply, divide). It accepts one element op at a time, pulses the start of
//   the selected unit for one cycle, and waits for that unit's busy to drop. It
//   then captures the unit's result and exception flag and holds them for the
//   execute->memory stage until stall_e_m releases. Only one op is ever in
//   flight, so at most one start_* output is high in any cycle.
//
//   Op sequence: IDLE -> ISSUE -> WAIT -> HOLD -> IDLE.
//   The reserved FU code (3) skips ISSUE/WAIT: it goes straight to HOLD with
//   lane_result = 0 and exception = 1, and no start is pulsed.
//
// Configuration macro
//   VLANE_PERF_CNT_EN : when defined, adds the saturating counters perf_ops
//                       (+1 per HOLD handoff) and perf_stall (+1 per HOLD cycle
//                       with stall_e_m high), plus the CNT_W parameter.
//
// Parameters
//   TAG_W  width of the element tag carried with each op
//   CNT_W  width of the performance counters (VLANE_PERF_CNT_EN only)
//
// Ports
//   CLK            clock
//   nRST           synchronous active-low reset
//   in_valid       op request
//   in_ready       sequencer can accept (high only in IDLE)
//   in_fu          unit select: 0=ARITH 1=MUL 2=DIV 3=reserved (illegal)
//   in_tag         tag returned with the result
//   start_a        one-cycle start to the arithmetic unit
//   start_mu       one-cycle start to the multiply unit
//   start_div      one-cycle start to the divide unit
//   busy_a/mu/du   unit busy flags
//   wdata_a/mu/du  unit results
//   exception_*    unit exception flags
//   stall_e_m      downstream stall; the result is held while high
//   out_valid      result valid (HOLD state)
//   lane_result    captured result
//   out_tag        tag of the captured result
//   exception      captured exception flag
//   busy           high in every state but IDLE
//   perf_ops       completed handoffs (VLANE_PERF_CNT_EN only)
//   perf_stall     stalled HOLD cycles (VLANE_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module vector_lane_fu_sequencer #(
    parameter int TAG_W = 5
`ifdef VLANE_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             CLK,
    input  logic             nRST,
    // request side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_fu,
    input  logic [TAG_W-1:0] in_tag,
    // unit starts
    output logic             start_a,
    output logic             start_mu,
    output logic             start_div,
    // unit status and results
    input  logic             busy_a,
    input  logic             busy_mu,
    input  logic             busy_du,
    input  logic [31:0]      wdata_a,
    input  logic [31:0]      wdata_mu,
    input  logic [31:0]      wdata_du,
    input  logic             exception_a,
    input  logic             exception_mu,
    input  logic             exception_du,
    // result side
    input  logic             stall_e_m,
    output logic             out_valid,
    output logic [31:0]      lane_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             exception,
    output logic             busy
`ifdef VLANE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_ops,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    // Unit select encoding.
    localparam logic [1:0] FU_ARITH = 2'd0;
    localparam logic [1:0] FU_MUL   = 2'd1;
    localparam logic [1:0] FU_DIV   = 2'd2;
    localparam logic [1:0] FU_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t             state_q;
    logic [1:0]         fu_q;
    logic [TAG_W-1:0]   tag_q;

    // Registered outputs.
    logic               in_ready_q;
    logic               start_a_q;
    logic               start_mu_q;
    logic               start_div_q;
    logic               out_valid_q;
    logic [31:0]        result_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic               exc_q;
    logic               busy_q;

    // Status of the unit selected by the latched op. Units that were not
    // selected are never looked at, so their busy flags may do anything.
    logic               sel_busy;
    logic [31:0]        sel_wdata;
    logic               sel_exc;

    always_comb begin
        sel_busy  = 1'b0;
        sel_wdata = 32'd0;
        sel_exc   = 1'b0;
        case (fu_q)
            FU_ARITH: begin
                sel_busy  = busy_a;
                sel_wdata = wdata_a;
                sel_exc   = exception_a;
            end
            FU_MUL: begin
                sel_busy  = busy_mu;
                sel_wdata = wdata_mu;
                sel_exc   = exception_mu;
            end
            FU_DIV: begin
                sel_busy  = busy_du;
                sel_wdata = wdata_du;
                sel_exc   = exception_du;
            end
            default: begin
                // Reserved code never reaches WAIT; values here are unused.
                sel_busy  = 1'b0;
                sel_wdata = 32'd0;
                sel_exc   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= ST_IDLE;
            fu_q        <= FU_ARITH;
            tag_q       <= '0;
            in_ready_q  <= 1'b1;
            start_a_q   <= 1'b0;
            start_mu_q  <= 1'b0;
            start_div_q <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            out_tag_q   <= '0;
            exc_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Starts are single-cycle pulses: cleared unless set below.
            start_a_q   <= 1'b0;
            start_mu_q  <= 1'b0;
            start_div_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // means a handshake here.
                    if (in_valid) begin
                        fu_q       <= in_fu;
                        tag_q      <= in_tag;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (in_fu == FU_RSVD) begin
                            // Illegal unit: report an exception without
                            // touching any functional unit.
                            state_q     <= ST_HOLD;
                            out_valid_q <= 1'b1;
                            result_q    <= 32'd0;
                            out_tag_q   <= in_tag;
                            exc_q       <= 1'b1;
                        end else begin
                            // The start registers rise together with ISSUE
                            // so the pulse is visible for the ISSUE cycle.
                            state_q     <= ST_ISSUE;
                            start_a_q   <= (in_fu == FU_ARITH);
                            start_mu_q  <= (in_fu == FU_MUL);
                            start_div_q <= (in_fu == FU_DIV);
                        end
                    end
                end

                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    // A unit raises busy the cycle after its start, so the
                    // first WAIT cycle with busy low means the result is ready
                    // (a zero-latency unit completes on the very first one).
                    if (!sel_busy) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                        result_q    <= sel_wdata;
                        out_tag_q   <= tag_q;
                        exc_q       <= sel_exc;
                    end
                end

                ST_HOLD: begin
                    // Handoff happens in the cycle stall_e_m is low; the
                    // captured values stay on the pins afterwards, only
                    // out_valid drops.
                    if (!stall_e_m) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign start_a     = start_a_q;
    assign start_mu    = start_mu_q;
    assign start_div   = start_div_q;
    assign out_valid   = out_valid_q;
    assign lane_result = result_q;
    assign out_tag     = out_tag_q;
    assign exception   = exc_q;
    assign busy        = busy_q;

`ifdef VLANE_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Saturating performance counters.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] perf_ops_q,   perf_ops_d;
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic             in_hold;

    assign in_hold = (state_q == ST_HOLD);

    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (in_hold && !stall_e_m && (perf_ops_q != {CNT_W{1'b1}})) begin
            perf_ops_d = perf_ops_q + 1'b1;
        end
        if (in_hold && stall_e_m && (perf_stall_q != {CNT_W{1'b1}})) begin
            perf_stall_d = perf_stall_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_vector_lane_fu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vector_lane_fu_sequencer
//   Directed bench for vector_lane_fu_sequencer. Stimulus pushes the expected
//   result of each op into a scoreboard queue; a monitor on the falling edge
//   compares every cycle out_valid is high and pops on handoff. Simple models
//   of the three units raise busy for a programmable number of cycles after
//   their start.
// -----------------------------------------------------------------------------
module tb_vector_lane_fu_sequencer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_fu = 2'd0;
    logic [4:0]  in_tag = 5'd0;
    logic        start_a, start_mu, start_div;
    logic        busy_a, busy_mu, busy_du;
    logic [31:0] wdata_a = 32'd0, wdata_mu = 32'd0, wdata_du = 32'd0;
    logic        exception_a = 1'b0, exception_mu = 1'b0, exception_du = 1'b0;
    logic        stall_e_m = 1'b0;
    logic        out_valid;
    logic [31:0] lane_result;
    logic [4:0]  out_tag;
    logic        exception;
    logic        busy;
`ifdef VLANE_PERF_CNT_EN
    logic [31:0] perf_ops, perf_stall;
`endif

    always #5 CLK = ~CLK;

    vector_lane_fu_sequencer dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_fu        (in_fu),
        .in_tag       (in_tag),
        .start_a      (start_a),
        .start_mu     (start_mu),
        .start_div    (start_div),
        .busy_a       (busy_a),
        .busy_mu      (busy_mu),
        .busy_du      (busy_du),
        .wdata_a      (wdata_a),
        .wdata_mu     (wdata_mu),
        .wdata_du     (wdata_du),
        .exception_a  (exception_a),
        .exception_mu (exception_mu),
        .exception_du (exception_du),
        .stall_e_m    (stall_e_m),
        .out_valid    (out_valid),
        .lane_result  (lane_result),
        .out_tag      (out_tag),
        .exception    (exception),
        .busy         (busy)
`ifdef VLANE_PERF_CNT_EN
        ,
        .perf_ops     (perf_ops),
        .perf_stall   (perf_stall)
`endif
    );

    // ---------------- functional unit models ----------------
    int   len_a = 0, len_mu = 0, len_du = 0;
    int   cnt_a = 0, cnt_mu = 0, cnt_du = 0;
    logic tog_en = 1'b0, tog = 1'b0;

    always @(posedge CLK) begin
        if (start_a) cnt_a <= len_a; else if (cnt_a > 0) cnt_a <= cnt_a - 1;
        if (start_mu) cnt_mu <= len_mu; else if (cnt_mu > 0) cnt_mu <= cnt_mu - 1;
        if (start_div) cnt_du <= len_du; else if (cnt_du > 0) cnt_du <= cnt_du - 1;
        tog <= ~tog;
    end

    assign busy_a  = (cnt_a > 0) | (tog_en & tog);
    assign busy_mu = (cnt_mu > 0);
    assign busy_du = (cnt_du > 0);

    // ---------------- checking infrastructure ----------------
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_start_a = 0, n_start_mu = 0, n_start_div = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Start pulse counting on the active edge (main thread reads on negedge).
    always @(posedge CLK) begin
        if (start_a)   n_start_a++;
        if (start_mu)  n_start_mu++;
        if (start_div) n_start_div++;
    end

    // Scoreboard monitor.
    always @(negedge CLK) begin
        if ((int'(start_a) + int'(start_mu) + int'(start_div)) > 1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL multi_start: got a=%b mu=%b div=%b required at most one",
                     start_a, start_mu, start_div);
        end
        if (nRST && out_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got out_valid=1 tag=%0d required no result",
                         out_tag);
            end else begin
                mon_e = sb_q[0];
                chk("lane_result", lane_result, mon_e.res);
                chk("out_tag", {27'd0, out_tag}, {27'd0, mon_e.tag});
                chk("exception", {31'd0, exception}, {31'd0, mon_e.exc});
                if (!stall_e_m) begin
                    void'(sb_q.pop_front());
                    $display("txn tag=%0d result=%h exception=%b", out_tag, lane_result, exception);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [1:0] fu, input logic [4:0] tag);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(negedge CLK);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: got in_ready=0 required 1");
        end
        in_valid = 1'b1;
        in_fu    = fu;
        in_tag   = tag;
        @(posedge CLK);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_ov(input string nm, input int limit);
        int w = 0;
        @(negedge CLK);
        while (!out_valid && w < limit) begin
            @(negedge CLK);
            w++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got out_valid=0 required 1", nm);
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int s_a, s_mu, s_div;
        int busy_cycles, fell_at, ov_at;
        logic rdy_bad;

        // Reset state.
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_lane_result", lane_result, 32'd0);
        chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
        chk("rst_exception", {31'd0, exception}, 32'd0);
        chk("rst_starts", {29'd0, start_a, start_mu, start_div}, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);

        // 1: ARITH, zero-busy unit, minimum latency.
        wdata_a = 32'h1234_5678;
        len_a   = 0;
        sb_q.push_back('{res: 32'h1234_5678, tag: 5'd3, exc: 1'b0});
        issue(2'd0, 5'd3);
        @(negedge CLK);                                  // c1
        chk("arith_start_c1", {31'd0, start_a}, 32'd1);
        chk("arith_in_ready_c1", {31'd0, in_ready}, 32'd0);
        @(negedge CLK);                                  // c2
        chk("arith_start_c2", {31'd0, start_a}, 32'd0);
        chk("arith_ov_c2", {31'd0, out_valid}, 32'd0);
        @(negedge CLK);                                  // c3
        chk("arith_ov_c3", {31'd0, out_valid}, 32'd1);
        @(negedge CLK);
        chk("arith_ov_after", {31'd0, out_valid}, 32'd0);
        chk("arith_idle_ready", {31'd0, in_ready}, 32'd1);
        chk("arith_start_count", n_start_a, 32'd1);

        // 2: DIV with busy_du high for 10 cycles.
        wdata_du = 32'hDEAD_BEEF;
        len_du   = 10;
        s_div    = n_start_div;
        sb_q.push_back('{res: 32'hDEAD_BEEF, tag: 5'd7, exc: 1'b0});
        issue(2'd2, 5'd7);
        busy_cycles = 0;
        fell_at = -1;
        ov_at = -1;
        rdy_bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (out_valid) begin
                ov_at = i;
                break;
            end
            if (busy_du) busy_cycles++;
            else if (busy_cycles > 0 && fell_at < 0) fell_at = i;
            if (in_ready) rdy_bad = 1'b1;
        end
        chk("div_busy_cycles", busy_cycles, 32'd10);
        chk("div_ov_after_fall", ov_at, fell_at + 1);
        chk("div_in_ready_low", {31'd0, rdy_bad}, 32'd0);
        chk("div_start_pulses", n_start_div - s_div, 32'd1);
        @(negedge CLK);
        chk("div_idle_ready", {31'd0, in_ready}, 32'd1);

        // 3: MUL with 5 stalled HOLD cycles.
        wdata_mu     = 32'hCAFE_F00D;
        exception_mu = 1'b0;
        len_mu       = 2;
        stall_e_m    = 1'b1;
        sb_q.push_back('{res: 32'hCAFE_F00D, tag: 5'd12, exc: 1'b0});
        issue(2'd1, 5'd12);
        wait_ov("mul_stall", 20);
        repeat (5) @(posedge CLK);
        #1 stall_e_m = 1'b0;
        @(negedge CLK);
        chk("mul_hold_sixth", {31'd0, out_valid}, 32'd1);
        chk("mul_busy_hold", {31'd0, busy}, 32'd1);
        @(negedge CLK);
        chk("mul_ov_released", {31'd0, out_valid}, 32'd0);
        chk("mul_idle_ready", {31'd0, in_ready}, 32'd1);
`ifdef VLANE_PERF_CNT_EN
        chk("perf_stall", perf_stall, 32'd5);
        chk("perf_ops", perf_ops, 32'd3);
`endif

        // 4: reserved unit code.
        s_a = n_start_a; s_mu = n_start_mu; s_div = n_start_div;
        sb_q.push_back('{res: 32'd0, tag: 5'd9, exc: 1'b1});
        issue(2'd3, 5'd9);
        @(negedge CLK);
        chk("rsvd_ov_next", {31'd0, out_valid}, 32'd1);
        @(negedge CLK);
        chk("rsvd_no_start", (n_start_a - s_a) + (n_start_mu - s_mu) + (n_start_div - s_div), 32'd0);
        chk("rsvd_idle_ready", {31'd0, in_ready}, 32'd1);

        // 6: MUL exception pass-through while busy_a toggles.
        wdata_mu     = 32'h0BAD_0001;
        exception_mu = 1'b1;
        len_mu       = 3;
        tog_en       = 1'b1;
        s_a          = n_start_a;
        sb_q.push_back('{res: 32'h0BAD_0001, tag: 5'd21, exc: 1'b1});
        issue(2'd1, 5'd21);
        wait_ov("mul_exc", 20);
        @(negedge CLK);
        tog_en       = 1'b0;
        exception_mu = 1'b0;
        chk("mulexc_no_start_a", n_start_a - s_a, 32'd0);
        chk("mulexc_idle_ready", {31'd0, in_ready}, 32'd1);

        // 5: reset during WAIT of a DIV op abandons it.
        len_du = 10;
        s_div  = n_start_div;
        issue(2'd2, 5'd4);
        repeat (3) @(negedge CLK);
        chk("rstop_busy_wait", {31'd0, busy}, 32'd1);
        nRST = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        chk("rstop_busy", {31'd0, busy}, 32'd0);
        chk("rstop_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstop_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (15) @(negedge CLK);
        chk("rstop_start_div", n_start_div - s_div, 32'd1);
        chk("rstop_still_idle", {31'd0, in_ready}, 32'd1);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
